uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmit engine for the UART peripheral, directly downstream of the UART register block. It buffers bytes written to TXDATA in a small FIFO and serialises them onto the `tx_o` line. Framing is 8 data bits, LSB first, with optional parity and one or two stop bits, at a bit period set by the divider register. It returns the 32-bit TX status word and a masked TX interrupt.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..128.
- `clk  in  1  system clock; one clock domain`
- `rst_n  in  1  asynchronous reset, active-low`
- `divider_i  in  32  clk cycles per bit (DIVIDER register)`
- `config_i  in  Config_t(6)  uart configuration (STATUS register)`
- `txirqmask_i  in  32  TX IRQ mask; bits [1:0] used`
- `tx_d_i  in  8  byte to send`
- `tx_d_valid_i  in  1  single-cycle write strobe; no back-pressure`
- `tx_o  out  1  serial line, idle high`
- `tx_status_o  out  32  TX status word`
- `tx_irq_o  out  1  TX interrupt, level`

## Operation
- Config_t fields, bit 0 upward: `tx_en`, `rx_en`, `parity_en`, `parity_odd`, `two_stop`, `loopback`. This block ignores `rx_en` and `loopback`.
- Strobe with FIFO not full: the byte is pushed.
- Strobe with FIFO full: the byte is dropped and sticky `overflow` is set.
- If a pop and a push happen in the same cycle with the FIFO full, the push is accepted.
- `overflow` clears only while `tx_en`=0.
- FSM states:
  - IDLE: `tx_o`=1. If `tx_en` and the FIFO is non-empty: pop, latch the byte, latch `D = max(divider_i, 1)`, latch the parity and stop settings, go to START.
  - START: drive 0 for D cycles, then go to DATA.
  - DATA: drive `shift[0]` for D cycles per bit, 8 bits LSB first; 3-bit bit counter. After bit 7: if `parity_en`, go to PARITY, else go to STOP.
  - PARITY: drive XOR of the data bits, XOR `parity_odd`, for D cycles.
  - STOP: drive 1 for D cycles, or 2D if `two_stop`. Then go to IDLE.
- Baud counter: 32-bit, loaded with D-1 on each bit entry, counts down, advances the bit at 0.
- Frame settings are latched at frame start. Changes to `divider_i` or `config_i` mid-frame take effect on the next frame.
- Clearing `tx_en` mid-frame: the current frame completes, no further pops occur, and FIFO contents are retained.
- Status word:
  - [0] busy (FSM not IDLE)
  - [1] fifo_empty
  - [2] fifo_full
  - [3] overflow
  - [15:8] fifo level
  - all other bits 0
- IRQ flags (TXIrqFlags_t):
  - [0] `idle`: FIFO empty and FSM IDLE.
  - [1] `half`: level < FIFO_DEPTH/2.
  - `tx_irq_o` = OR(flags & `txirqmask_i[1:0]`), registered.

## Timing
- Reset values:
  - `tx_o`=1 (asserted immediately on reset, also mid-frame)
  - `tx_status_o` = 32'h0000_0002 (fifo_empty)
  - `tx_irq_o`=0
  - FIFO empty, FSM IDLE, overflow cleared
- Latency: strobe in cycle N → entry visible in the FIFO at N+1 → start bit on `tx_o` from N+2 when idle and enabled.
- Frame duration is D × (10 + parity_en + two_stop) cycles.
- Back-to-back frames: IDLE is occupied for exactly one cycle between a stop bit and the next start bit.
- `tx_status_o` is registered and reflects state one cycle after the event.
- `tx_irq_o` follows flag changes by 1 cycle.

## Structure
- `uart_defs` package holds:
  - Config_t (packed, 6 bits)
  - TXIrqFlags_t (packed, 2 bits)
  - TXState_t enum {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP}
  - status bit index constants
- Sub-module `uart_tx_fifo`:
  - parameterised synchronous FIFO
  - push/pop/full/empty/level ports
  - pointers one bit wider than the address for full/empty detection

## Test plan
- D=4, no parity, one stop; write 8'hA5 → `tx_o`: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1; busy=1 for 40 cycles.
- D=2, parity_en=1, parity_odd=0; write 8'h07 → parity bit 1; frame is 22 cycles. With parity_odd=1 → parity bit 0.
- D=1, two_stop=1, FIFO_DEPTH=8; 10 strobes in consecutive cycles while `tx_en`=0 → fifo_full=1, level=8, overflow=1. Then set `tx_en`=1 → 8 frames of 11 cycles, each separated by one idle cycle.
- divider_i=0 → bit period 1 cycle. divider_i changed from 4 to 8 mid-frame → the current frame stays at 4, the next frame uses 8.
- txirqmask=2'b01: `tx_irq_o`=1 from reset. After one write, `tx_irq_o` drops at N+2 (one cycle after the flag changes) and rises 1 cycle after the frame ends.
- `rst_n` pulled low during DATA → `tx_o`=1 immediately, status=32'h2; after release, a new write transmits normally.

Source files
------------

// File: rtl/uart_defs.sv
// Shared types and constants for the UART transmit path.
`timescale 1ns/1ps
package uart_defs;

    // Packed MSB-first, so tx_en lands on bit 0.
    typedef struct packed {
        logic loopback;
        logic two_stop;
        logic parity_odd;
        logic parity_en;
        logic rx_en;
        logic tx_en;
    } Config_t;

    typedef struct packed {
        logic half;
        logic idle;
    } TXIrqFlags_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } TXState_t;

    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_FULL      = 2;
    localparam int unsigned ST_OVERFLOW  = 3;
    localparam int unsigned ST_LEVEL_LSB = 8;

    // A zero divider would stall the baud counter; treat it as one cycle per bit.
    function automatic logic [31:0] bit_period(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the register block and the serialiser; pointers carry a wrap bit.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic [7:0]  data_i,
    input  logic        pop_i,
    output logic [7:0]  data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] level_o
);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(do_push);
        rptr_d = rptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: FIFO-buffered bytes serialised as start/8 data/parity/stop frames.
`timescale 1ns/1ps
module uart_tx
    import uart_defs::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] divider_i,
    input  Config_t     config_i,
    input  logic [31:0] txirqmask_i,
    input  logic [7:0]  tx_d_i,
    input  logic        tx_d_valid_i,
    output logic        tx_o,
    output logic [31:0] tx_status_o,
    output logic        tx_irq_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] HALF = (AW+1)'(FIFO_DEPTH / 2);

    logic [7:0]  fifo_data;
    logic        fifo_full, fifo_empty, pop;
    logic [AW:0] fifo_level;

    TXState_t    state_q;
    logic        tx_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [31:0] baud_q, period_q;
    logic        par_en_q, par_bit_q, two_stop_q, stop2_q;

    logic        overflow_q, overflow_d;
    logic [31:0] status_q, status_d;
    logic        irq_q, irq_d;
    TXIrqFlags_t flags;
    logic        drop;

    logic unused_inputs;
    assign unused_inputs = ^{config_i.rx_en, config_i.loopback, txirqmask_i[31:2]};

    assign pop  = (state_q == TX_IDLE) && config_i.tx_en && !fifo_empty;
    assign drop = tx_d_valid_i && fifo_full && !pop;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_d_valid_i),
        .data_i  (tx_d_i),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Frame settings are captured on the pop so register writes mid-frame wait for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_q     <= '0;
            period_q   <= 32'd1;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            unique case (state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q    <= fifo_data;
                        period_q   <= bit_period(divider_i);
                        baud_q     <= bit_period(divider_i) - 32'd1;
                        par_en_q   <= config_i.parity_en;
                        par_bit_q  <= (^fifo_data) ^ config_i.parity_odd;
                        two_stop_q <= config_i.two_stop;
                        stop2_q    <= 1'b0;
                        tx_q       <= 1'b0;
                        state_q    <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_q == 32'd0) begin
                        baud_q    <= period_q - 32'd1;
                        bit_cnt_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= TX_DATA;
                    end else begin
                        baud_q <= baud_q - 32'd1;
                    end
                end
                TX_DATA: begin
                    if (baud_q == 32'd0) begin
                        baud_q <= period_q - 32'd1;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= par_en_q ? par_bit_q : 1'b1;
                            state_q <= par_en_q ? TX_PARITY : TX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 32'd1;
                    end
                end
                TX_PARITY: begin
                    if (baud_q == 32'd0) begin
                        baud_q  <= period_q - 32'd1;
                        tx_q    <= 1'b1;
                        state_q <= TX_STOP;
                    end else begin
                        baud_q <= baud_q - 32'd1;
                    end
                end
                TX_STOP: begin
                    if (baud_q == 32'd0) begin
                        if (two_stop_q && !stop2_q) begin
                            stop2_q <= 1'b1;
                            baud_q  <= period_q - 32'd1;
                        end else begin
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 32'd1;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        // A drop always sets the flag; otherwise it only survives while the transmitter is enabled.
        overflow_d = drop | (overflow_q & config_i.tx_en);

        status_d                               = '0;
        status_d[ST_BUSY]                      = (state_q != TX_IDLE);
        status_d[ST_EMPTY]                     = fifo_empty;
        status_d[ST_FULL]                      = fifo_full;
        status_d[ST_OVERFLOW]                  = overflow_q;
        status_d[ST_LEVEL_LSB +: 8]            = 8'(fifo_level);

        flags.idle = fifo_empty && (state_q == TX_IDLE);
        flags.half = (fifo_level < HALF);
        irq_d      = |(flags & txirqmask_i[1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            status_q   <= 32'h0000_0002;
            irq_q      <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            status_q   <= status_d;
            irq_q      <= irq_d;
        end
    end

    assign tx_o        = tx_q;
    assign tx_status_o = status_q;
    assign tx_irq_o    = irq_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: a line monitor compares each frame to its expected waveform.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_defs::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] divider;
    Config_t     cfg;
    logic [31:0] irqmask;
    logic [7:0]  tx_d;
    logic        tx_v;
    logic        tx_o;
    logic [31:0] status;
    logic        irq;

    uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .divider_i    (divider),
        .config_i     (cfg),
        .txirqmask_i  (irqmask),
        .tx_d_i       (tx_d),
        .tx_d_valid_i (tx_v),
        .tx_o         (tx_o),
        .tx_status_o  (status),
        .tx_irq_o     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         d;
        bit         par_en;
        bit         par_odd;
        bit         two_stop;
    } frame_t;

    int     checks = 0;
    int     errors = 0;
    frame_t sb[$];
    frame_t cur;
    bit     wave[$];
    int     widx, bad_idx;
    bit     wbad, bad_got;
    bit     mon_busy = 1'b0;
    bit     stray = 1'b0;
    int     cyc = 0;
    int     starts[$];

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic int dval(logic [31:0] v);
        return (v == 32'd0) ? 1 : int'(v);
    endfunction

    // Line monitor: each falling edge from idle starts a frame, sampled once per clock.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mon_busy = 1'b0;
            stray    = 1'b0;
        end else if (mon_busy) begin
            if (tx_o !== wave[widx] && !wbad) begin
                wbad = 1'b1; bad_idx = widx; bad_got = tx_o;
            end
            widx++;
            if (widx == wave.size()) begin
                mon_busy = 1'b0;
                checks++;
                if (wbad) begin
                    errors++;
                    $display("FAIL frame data=%h d=%0d sample %0d got=%b want=%b",
                             cur.data, cur.d, bad_idx, bad_got, wave[bad_idx]);
                end
            end
        end else if (tx_o === 1'b1) begin
            stray = 1'b0;
        end else if (!stray) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                stray = 1'b1;
                $display("FAIL unexpected_frame got=start_bit want=idle_line");
            end else begin
                cur = sb.pop_front();
                wave.delete();
                repeat (cur.d) wave.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (cur.d) wave.push_back(cur.data[i]);
                if (cur.par_en)
                    repeat (cur.d) wave.push_back(1'(($countones(cur.data) + int'(cur.par_odd)) % 2));
                repeat (cur.d * (cur.two_stop ? 2 : 1)) wave.push_back(1'b1);
                widx = 1; wbad = 1'b0; mon_busy = 1'b1;
                starts.push_back(cyc);
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(logic [7:0] b, int d);
        frame_t f;
        f.data = b; f.d = d;
        f.par_en = cfg.parity_en; f.par_odd = cfg.parity_odd; f.two_stop = cfg.two_stop;
        sb.push_back(f);
    endtask

    task automatic write(logic [7:0] b);
        tx_d = b; tx_v = 1'b1;
        step();
        tx_v = 1'b0;
    endtask

    task automatic send(logic [7:0] b, int d);
        expect_frame(b, d);
        write(b);
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((sb.size() != 0 || mon_busy || status[0]) && n < 5000) begin
            step(); n++;
        end
        check(name, 32'(n < 5000), 32'd1);
        step(3);
    endtask

    initial begin
        int busy_cnt, lvl, base, nb;
        logic [7:0] b;
        cfg = '0; divider = 32'd4; irqmask = 32'd1; tx_d = '0; tx_v = 1'b0;

        step(2);
        check("rst_tx_o", 32'(tx_o), 32'd1);
        check("rst_status", status, 32'h0000_0002);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        step(2);
        check("irq_from_reset", 32'(irq), 32'd1);

        // D=4, 8'hA5: latency, busy span and idle-IRQ timing
        cfg.tx_en = 1'b1;
        send(8'hA5, 4);
        check("irq_before", 32'(irq), 32'd1);
        check("line_idle_n1", 32'(tx_o), 32'd1);
        step();
        check("start_latency", 32'(tx_o), 32'd0);
        check("irq_drop", 32'(irq), 32'd0);
        busy_cnt = int'(status[0]);
        for (int k = 2; k <= 41; k++) begin
            step();
            busy_cnt += int'(status[0]);
        end
        check("irq_at_frame_end", 32'(irq), 32'd0);
        step();
        busy_cnt += int'(status[0]);
        check("irq_rise", 32'(irq), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'd40);
        wait_idle("idle_a5");

        // Parity, D=2
        divider = 32'd2; cfg.parity_en = 1'b1; cfg.parity_odd = 1'b0;
        send(8'h07, 2);
        wait_idle("idle_par_even");
        cfg.parity_odd = 1'b1;
        send(8'h07, 2);
        wait_idle("idle_par_odd");

        // Overflow with tx disabled, then back-to-back drain, D=1, two stop bits
        cfg.tx_en = 1'b0; cfg.parity_en = 1'b0; cfg.parity_odd = 1'b0; cfg.two_stop = 1'b1;
        divider = 32'd1;
        lvl = 0;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            tx_d = b; tx_v = 1'b1;
            if (lvl < DEPTH) begin
                expect_frame(b, 1);
                lvl++;
            end
            step();
        end
        tx_v = 1'b0;
        check("ovf_level", 32'(status[15:8]), 32'(lvl));
        check("ovf_full", 32'(status[2]), 32'd1);
        check("ovf_flag", 32'(status[3]), 32'd1);
        check("ovf_no_tx", 32'(tx_o), 32'd1);
        base = starts.size();
        cfg.tx_en = 1'b1;
        wait_idle("idle_drain");
        check("drain_frames", 32'(starts.size() - base), 32'd8);
        for (int i = 1; i < 8 && base + i < starts.size(); i++)
            check("b2b_gap", 32'(starts[base+i] - starts[base+i-1]), 32'd12);

        // Divider change mid-frame, then divider zero
        cfg.two_stop = 1'b0; divider = 32'd4;
        send(8'h3C, 4);
        send(8'hC3, 8);
        step(5);
        divider = 32'd8;
        wait_idle("idle_div_change");
        divider = 32'd0;
        send(8'h5A, 1);
        wait_idle("idle_div_zero");

        // Randomised bursts
        for (int r = 0; r < 6; r++) begin
            cfg.parity_en  = 1'($urandom_range(0, 1));
            cfg.parity_odd = 1'($urandom_range(0, 1));
            cfg.two_stop   = 1'($urandom_range(0, 1));
            divider        = 32'($urandom_range(0, 5));
            nb             = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < nb; i++) send(8'($urandom), dval(divider));
            wait_idle("idle_random");
        end

        // Reset mid-DATA
        cfg.parity_en = 1'b0; cfg.parity_odd = 1'b0; cfg.two_stop = 1'b0; divider = 32'd4;
        send(8'h00, 4);
        step(10);
        check("pre_rst_data_low", 32'(tx_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midframe_rst_tx_o", 32'(tx_o), 32'd1);
        check("midframe_rst_status", status, 32'h0000_0002);
        sb.delete();
        step(2);
        rst_n = 1'b1;
        step(2);
        send(8'h96, 4);
        wait_idle("idle_after_rst");

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
